prio_arbiter: RTL and testbench
===============================

Name: prio_arbiter

Overview:
- Parametrised, registered successor to the 8-input combinational priority encoder.
- Arbitrates N request lines and holds one grant until the owner releases it.
- Supports fixed priority (bit 0 highest) or round-robin, selected at elaboration.
- Sits in front of a shared resource (bus, memory port). Encoded and one-hot grants are registered, and the idle index is defined (never X).

Parameters:
- N, 8, number of request lines (2..32).
- IDX_W, 3, width of the encoded grant index; must equal ceil(log2(N)).
- RR_MODE, 0, 0 = fixed priority with req[0] highest; 1 = round-robin starting from the rotating pointer.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N  request lines; bit i is requester i.
- done  input  1  owner releases the grant; sampled only in GRANT.
- grant  output  N  one-hot registered grant; all zero when idle.
- grant_idx  output  IDX_W  index of the granted requester; 0 when idle.
- grant_valid  output  1  high while a grant is held.
- busy  output  1  equals grant_valid; provided for status and debug.

Behaviour:
- Reset: rst_n low asynchronously forces state=IDLE, grant=0, grant_idx=0, grant_valid=0, busy=0, rr_ptr=0. Release is synchronous to clk.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - If req != 0 at a clk edge: select a winner, load grant/grant_idx, set grant_valid, go to GRANT.
  - Latency is 1 cycle, from req sampled to grant_valid high.
  - If req == 0: stay in IDLE with outputs at zero.
- Winner selection:
  - RR_MODE=0: lowest set index of req.
  - RR_MODE=1: first set bit scanning upward from rr_ptr, wrapping from N-1 to 0.
  - The winner is always a bit set in req in the sampled cycle.
- GRANT:
  - Grant is held stable regardless of other req changes, including higher-priority arrivals. There is no preemption.
  - Exit when done=1 or req[grant_idx]=0 at a clk edge. Both conditions are treated identically.
  - On exit: clear grant, grant_idx and grant_valid the next cycle, and return to IDLE.
  - No back-to-back grants: at least one IDLE cycle always separates grants.
- Round-robin pointer:
  - On each grant exit, rr_ptr <= grant_idx+1, wrapping to 0 when grant_idx == N-1.
  - In RR_MODE=0 the pointer is unused and held at 0.
- done in IDLE is ignored.
- done together with new requests on the exit edge: the exit takes effect and the new requests are arbitrated in the following IDLE cycle.
- Invariants:
  - grant is always one-hot or zero.
  - grant == (1 << grant_idx) whenever grant_valid=1.
  - grant_idx=0 and grant=0 whenever grant_valid=0.
- Reset mid-grant: outputs clear immediately (asynchronously). No release is recorded, and rr_ptr returns to 0.
- Indices >= N are unreachable by construction. Port widths and the IDX_W relation are checked at elaboration.

Test Plan:
- Reset/idle: hold rst_n=0 with req=8'hFF, then release with req=0 -> grant=0, grant_idx=0, grant_valid=0 for 5 cycles.
- Fixed priority (RR_MODE=0, N=8): req=8'b1010_0100 -> one cycle later grant=8'b0000_0100, grant_idx=2. Then raise req[0] -> grant stays at index 2 until done=1. After exit, one idle cycle, then grant_idx=0.
- Release by dropping request: grant held on index 5, deassert req[5] -> next cycle grant_valid=0. With req[7] still high, grant_idx=7 one cycle after that.
- Round-robin (RR_MODE=1, N=4): req=4'b1111 held, pulse done one cycle after each grant -> grant_idx sequence 0,1,2,3,0, with a single idle cycle between each.
- RR wrap and sparse requests (N=4): rr_ptr=3 after grant 2 exits, req=4'b0011 -> grant_idx=0. Next exit sets rr_ptr=1.
- Async reset mid-grant: grant held on index 6, assert rst_n=0 between clock edges -> grant=0 and grant_valid=0 without waiting for a clock edge. After release with req=8'h40 -> grant_idx=6 one cycle later.

Source files
------------

// File: rtl/prio_arbiter.sv
// -----------------------------------------------------------------------------
// prio_arbiter
//
// Registered N-way arbiter for a shared resource (bus, memory port). When the
// arbiter is idle it picks one active requester and grants it. It then holds
// that grant, without preemption, until the owner releases it. The owner
// releases by pulsing done or by dropping its request. At least one idle
// cycle always separates two grants.
//
// Winner selection is fixed at elaboration:
//   RR_MODE = 0 : fixed priority, req[0] highest.
//   RR_MODE = 1 : round-robin. The scan starts at a rotating pointer that
//                 moves to just past the previous owner each time a grant ends.
//
// Parameters:
//   N        number of request lines (2..32)
//   IDX_W    width of the encoded grant index, must equal $clog2(N)
//   RR_MODE  0 = fixed priority, 1 = round-robin
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req          request lines, bit i belongs to requester i
//   done         owner releases the grant (ignored while idle)
//   grant        registered one-hot grant, all zero when idle
//   grant_idx    registered index of the owner, 0 when idle
//   grant_valid  high while a grant is held
//   busy         copy of grant_valid for status/debug
// -----------------------------------------------------------------------------
module prio_arbiter #(
   parameter int N       = 8,
   parameter int IDX_W   = 3,
   parameter bit RR_MODE = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   input  logic             done,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid,
   output logic             busy
);

   // ---------------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ---------------------------------------------------------------------------
   if (N < 2 || N > 32) begin : g_bad_n
      $error("prio_arbiter: N=%0d is outside the supported range 2..32", N);
   end

   if (IDX_W != $clog2(N)) begin : g_bad_idx_w
      $error("prio_arbiter: IDX_W=%0d must equal $clog2(N)=%0d", IDX_W, $clog2(N));
   end

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   state_e           state_q,     state_d;
   logic [N-1:0]     grant_q,     grant_d;
   logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
   logic [IDX_W-1:0] rr_ptr_q,    rr_ptr_d;

   // Winner of the current cycle's requests (valid only when win_found)
   logic             win_found;
   logic [IDX_W-1:0] win_idx;
   logic [IDX_W-1:0] scan_start;

   // Owner gives the grant up
   logic             release_grant;

   // ---------------------------------------------------------------------------
   // Winner selection
   //
   // Scan N positions starting at scan_start and wrap past N-1. The first set
   // bit wins. With scan_start tied to 0 this reduces to plain lowest-index
   // priority, so both modes share one scan loop.
   // ---------------------------------------------------------------------------
   assign scan_start = RR_MODE ? rr_ptr_q : '0;

   // NOTE: every signal written in an always_comb gets a default before any
   // conditional assignment. A path that leaves a signal unassigned would
   // otherwise infer a latch.
   always_comb begin
      int cand;
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      for (int k = 0; k < N; k++) begin
         cand = int'(scan_start) + k;
         if (cand >= N) begin
            cand = cand - N;
         end
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand[IDX_W-1:0];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state / output logic
   // ---------------------------------------------------------------------------
   // done and a dropped request are handled the same way
   assign release_grant = done || !req[grant_idx_q];

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      grant_idx_d = grant_idx_q;
      rr_ptr_d    = rr_ptr_q;

      case (state_q)
         IDLE: begin
            // win_found is equivalent to req != 0
            if (win_found) begin
               state_d          = GRANT;
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
               grant_idx_d      = win_idx;
            end
         end

         GRANT: begin
            // Requests that arrive on the exit edge are not looked at here.
            // They are arbitrated in the IDLE cycle that follows, which also
            // enforces the mandatory gap between grants.
            if (release_grant) begin
               state_d     = IDLE;
               grant_d     = '0;
               grant_idx_d = '0;
               if (RR_MODE) begin
                  rr_ptr_d = (grant_idx_q == IDX_W'(N - 1)) ? '0
                                                            : grant_idx_q + 1'b1;
               end
            end
         end

         default: begin
            state_d     = IDLE;
            grant_d     = '0;
            grant_idx_d = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only. All flops then
   // update together from the values before the edge, so the result does not
   // depend on the order in which blocks are evaluated.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         grant_idx_q <= '0;
         rr_ptr_q    <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         grant_idx_q <= grant_idx_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs, all taken straight from flops
   // ---------------------------------------------------------------------------
   assign grant       = grant_q;
   assign grant_idx   = grant_idx_q;
   assign grant_valid = (state_q == GRANT);
   assign busy        = grant_valid;

endmodule

// File: tb/tb_prio_arbiter.sv
// -----------------------------------------------------------------------------
// tb_prio_arbiter
//
// Drives two arbiters side by side: a fixed-priority N=8 instance and a
// round-robin N=4 instance. Each is compared every cycle against a
// behavioural model. The model tracks only "who owns the resource" (-1 when
// idle) and "where the round-robin scan starts".
// -----------------------------------------------------------------------------
module tb_prio_arbiter;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   // fixed-priority instance
   logic [7:0] req_fp;
   logic       done_fp;
   logic [7:0] grant_fp;
   logic [2:0] idx_fp;
   logic       gv_fp;
   logic       busy_fp;

   // round-robin instance
   logic [3:0] req_rr;
   logic       done_rr;
   logic [3:0] grant_rr;
   logic [1:0] idx_rr;
   logic       gv_rr;
   logic       busy_rr;

   prio_arbiter #(.N(8), .IDX_W(3), .RR_MODE(1'b0)) u_fp (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req_fp),
      .done        (done_fp),
      .grant       (grant_fp),
      .grant_idx   (idx_fp),
      .grant_valid (gv_fp),
      .busy        (busy_fp)
   );

   prio_arbiter #(.N(4), .IDX_W(2), .RR_MODE(1'b1)) u_rr (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req_rr),
      .done        (done_rr),
      .grant       (grant_rr),
      .grant_idx   (idx_rr),
      .grant_valid (gv_rr),
      .busy        (busy_rr)
   );

   int total = 0;
   int bad   = 0;

   // model state per instance: 0 = fixed priority, 1 = round-robin
   int owner [2];
   int ptr   [2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         owner[u] = -1;
         ptr[u]   = 0;
      end
   endtask

   // One clock edge of the arbitration rules, stated directly
   task automatic model_step(input int u, input logic [7:0] r, input logic d,
                             input int n, input bit rr);
      if (owner[u] < 0) begin
         for (int k = 0; k < n; k++) begin
            int i;
            i = rr ? (ptr[u] + k) % n : k;
            if (owner[u] < 0 && r[i]) owner[u] = i;
         end
      end else if (d || !r[owner[u]]) begin
         if (rr) ptr[u] = (owner[u] + 1) % n;
         owner[u] = -1;
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".fp.grant"}, 32'(grant_fp), owner[0] < 0 ? 32'd0 : 32'd1 << owner[0]);
      check({tag, ".fp.idx"},   32'(idx_fp),   owner[0] < 0 ? 32'd0 : 32'(owner[0]));
      check({tag, ".fp.valid"}, 32'(gv_fp),    32'(owner[0] >= 0));
      check({tag, ".fp.busy"},  32'(busy_fp),  32'(owner[0] >= 0));
      check({tag, ".rr.grant"}, 32'(grant_rr), owner[1] < 0 ? 32'd0 : 32'd1 << owner[1]);
      check({tag, ".rr.idx"},   32'(idx_rr),   owner[1] < 0 ? 32'd0 : 32'(owner[1]));
      check({tag, ".rr.valid"}, 32'(gv_rr),    32'(owner[1] >= 0));
      check({tag, ".rr.busy"},  32'(busy_rr),  32'(owner[1] >= 0));
   endtask

   // Apply inputs, take one rising edge, advance the model, compare
   task automatic step(input string tag, input logic [7:0] rf, input logic df,
                       input logic [3:0] rr, input logic dr);
      req_fp  = rf;
      done_fp = df;
      req_rr  = rr;
      done_rr = dr;
      @(posedge clk);
      model_step(0, rf, df, 8, 1'b0);
      model_step(1, {4'b0, rr}, dr, 4, 1'b1);
      #1;
      compare_all(tag);
   endtask

   // Assert reset between edges (called at posedge+1) and release before the next edge
   task automatic mid_cycle_reset(input string tag);
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all(tag);
      #2;
      rst_n = 1'b1;
   endtask

   int exp_rr_seq [7] = '{0, 1, 2, 3, 0, 1, 2};

   initial begin
      model_reset();
      req_fp  = 8'hFF;
      done_fp = 1'b0;
      req_rr  = 4'hF;
      done_rr = 1'b0;

      // reset held with all requests asserted
      #22;
      compare_all("rst");
      req_fp = 8'h00;
      req_rr = 4'h0;
      rst_n  = 1'b1;
      for (int i = 0; i < 5; i++) step("idle", 8'h00, 1'b0, 4'h0, 1'b0);

      // fixed priority: lowest index wins, no preemption by req[0]
      step("fp_pick", 8'hA4, 1'b0, 4'h0, 1'b0);
      check("fp_idx2", 32'(idx_fp), 32'd2);
      check("fp_onehot2", 32'(grant_fp), 32'h04);
      for (int i = 0; i < 3; i++) step("fp_hold", 8'hA5, 1'b0, 4'h0, 1'b0);
      check("fp_no_preempt", 32'(idx_fp), 32'd2);
      step("fp_done", 8'hA5, 1'b1, 4'h0, 1'b0);
      check("fp_exit_gap", 32'(gv_fp), 32'd0);
      step("fp_regrant", 8'hA5, 1'b0, 4'h0, 1'b0);
      check("fp_idx0", 32'(idx_fp), 32'd0);
      step("fp_done2", 8'hA5, 1'b1, 4'h0, 1'b0);

      // release by dropping the request
      step("fp_pick5", 8'hA0, 1'b0, 4'h0, 1'b0);
      check("fp_idx5", 32'(idx_fp), 32'd5);
      step("fp_drop5", 8'h80, 1'b0, 4'h0, 1'b0);
      check("fp_drop_exit", 32'(gv_fp), 32'd0);
      step("fp_pick7", 8'h80, 1'b0, 4'h0, 1'b0);
      check("fp_idx7", 32'(idx_fp), 32'd7);
      step("fp_drop7", 8'h00, 1'b0, 4'h0, 1'b0);
      step("fp_idle", 8'h00, 1'b0, 4'h0, 1'b0);

      // round-robin rotation with all requesters active
      for (int j = 0; j < 7; j++) begin
         step("rr_grant", 8'h00, 1'b0, 4'hF, 1'b0);
         check($sformatf("rr_seq%0d", j), 32'(idx_rr), 32'(exp_rr_seq[j]));
         step("rr_done", 8'h00, 1'b0, 4'hF, 1'b1);
         check($sformatf("rr_gap%0d", j), 32'(gv_rr), 32'd0);
      end
      // pointer now 3; sparse requests wrap to 0, then next exit moves it to 1
      step("rr_wrap", 8'h00, 1'b0, 4'h3, 1'b0);
      check("rr_wrap_idx0", 32'(idx_rr), 32'd0);
      step("rr_wrap_done", 8'h00, 1'b1, 4'h3, 1'b1);
      step("rr_next", 8'h00, 1'b0, 4'h3, 1'b0);
      check("rr_next_idx1", 32'(idx_rr), 32'd1);
      step("rr_drop", 8'h00, 1'b0, 4'h0, 1'b0);

      // async reset in the middle of a grant
      step("arst_pick6", 8'h40, 1'b0, 4'h4, 1'b0);
      check("arst_idx6", 32'(idx_fp), 32'd6);
      req_fp = 8'h40;
      mid_cycle_reset("arst");
      check("arst_gv_now", 32'(gv_fp), 32'd0);
      step("arst_regrant", 8'h40, 1'b0, 4'h0, 1'b0);
      check("arst_regrant6", 32'(idx_fp), 32'd6);
      step("arst_done", 8'h40, 1'b1, 4'h0, 1'b0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [7:0] rf;
         logic [3:0] rr;
         logic       df;
         logic       dr;
         rf = 8'($urandom);
         if ($urandom_range(0, 1) == 0) rf = rf & 8'($urandom);
         rr = 4'($urandom);
         if ($urandom_range(0, 2) == 0) rr = rr & 4'($urandom);
         df = ($urandom_range(0, 3) == 0);
         dr = ($urandom_range(0, 3) == 0);
         step("rand", rf, df, rr, dr);
         if ($urandom_range(0, 299) == 0) mid_cycle_reset("rand_arst");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
